// File: rtl/mul_flag_unit_pkg.sv
// rtl/mul_flag_unit_pkg.sv - shared state encoding and sizing for the multiply/flag unit
package mul_flag_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_flag_unit_if.sv
// rtl/mul_flag_unit_if.sv - operand/result bundle between issuing logic and the multiply unit
interface mul_flag_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_in;
    logic             S_bit_in;
    logic             accumulate_in;
    logic [WIDTH-1:0] Rm_in;
    logic [WIDTH-1:0] Rs_in;
    logic [WIDTH-1:0] Rn_in;
    logic             C_in;
    logic             V_in;
    logic [WIDTH-1:0] result_out;
    logic             Z_out;
    logic             N_out;
    logic             C_out;
    logic             V_out;
    logic             S_bit_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, S_bit_in, accumulate_in, Rm_in, Rs_in, Rn_in, C_in, V_in,
        input  result_out, Z_out, N_out, C_out, V_out, S_bit_out, busy_out, done_out
    );

    modport slave (
        input  start_in, S_bit_in, accumulate_in, Rm_in, Rs_in, Rn_in, C_in, V_in,
        output result_out, Z_out, N_out, C_out, V_out, S_bit_out, busy_out, done_out
    );

endinterface

// File: rtl/mul_flag_unit_flag_gen.sv
// rtl/mul_flag_unit_flag_gen.sv - condition codes from a result; C and V pass through
module flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result,
    input  logic             c_in,
    input  logic             v_in,
    output logic             n_out,
    output logic             z_out,
    output logic             c_out,
    output logic             v_out
);

    assign n_out = result[WIDTH-1];
    assign z_out = (result == '0);
    assign c_out = c_in;
    assign v_out = v_in;

endmodule

// File: rtl/mul_flag_unit.sv
// rtl/mul_flag_unit.sv - sequential shift-add MUL/MLA with PSR flag generation
module mul_flag_unit
    import mul_flag_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mul_flag_unit_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // set once the last multiplier bit has been added; MULT exits on the following cycle
    logic             last_q, last_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] rn_q, rn_d;
    logic             acc_q, acc_d;
    logic             s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             cf_q, cf_d;
    logic             vf_q, vf_d;

    logic             publish;
    logic [WIDTH-1:0] final_val;
    logic             fg_n, fg_z, fg_c, fg_v;

    flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (final_val),
        .c_in   (c_q),
        .v_in   (v_q),
        .n_out  (fg_n),
        .z_out  (fg_z),
        .c_out  (fg_c),
        .v_out  (fg_v)
    );

    // next state, shift-add datapath and result/flag publication on entry to DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        rn_d      = rn_q;
        acc_d     = acc_q;
        s_d       = s_q;
        c_d       = c_q;
        v_d       = v_q;
        result_d  = result_q;
        n_d       = n_q;
        z_d       = z_q;
        cf_d      = cf_q;
        vf_d      = vf_q;
        publish   = 1'b0;
        final_val = prod_q;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    last_d   = 1'b0;
                    mcand_d  = bus.Rm_in;
                    mplier_d = bus.Rs_in;
                    prod_d   = '0;
                    rn_d     = bus.Rn_in;
                    acc_d    = bus.accumulate_in;
                    s_d      = bus.S_bit_in;
                    c_d      = bus.C_in;
                    v_d      = bus.V_in;
                end
            end
            MULT: begin
                if (!last_q) begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (acc_q) begin
                    state_d = ACC;
                end else begin
                    state_d = DONE;
                    publish = 1'b1;
                end
            end
            ACC: begin
                final_val = prod_q + rn_q;
                state_d   = DONE;
                publish   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (publish) begin
            result_d = final_val;
            n_d      = fg_n;
            z_d      = fg_z;
            cf_d     = fg_c;
            vf_d     = fg_v;
        end
    end

    // state, counter and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            rn_q     <= '0;
            acc_q    <= 1'b0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            rn_q     <= rn_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
            c_q      <= c_d;
            v_q      <= v_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            cf_q     <= cf_d;
            vf_q     <= vf_d;
        end
    end

    assign bus.result_out = result_q;
    assign bus.N_out      = n_q;
    assign bus.Z_out      = z_q;
    assign bus.C_out      = cf_q;
    assign bus.V_out      = vf_q;
    // the PSR write enable is confined to the DONE cycle
    assign bus.S_bit_out  = s_q & (state_q == DONE);
    assign bus.busy_out   = (state_q != IDLE);
    assign bus.done_out   = (state_q == DONE);

endmodule

// File: doc/mul_flag_unit.md
MUL_FLAG_UNIT -- requirements
Module: mul_flag_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start_in  input  1  starts one multiply; sampled only in IDLE.
REQ-006 S_bit_in  input  1  instruction S bit; captured at start.
REQ-007 accumulate_in  input  1  1 = MLA (Rm*Rs+Rn), 0 = MUL (Rm*Rs); captured at start.
REQ-008 Rm_in, Rs_in, Rn_in  input  WIDTH each  operands; captured at start.
REQ-009 C_in, V_in  input  1 each  current PSR C and V flags; captured at start.
REQ-010 result_out  output  WIDTH  product, low WIDTH bits.
REQ-011 Z_out, N_out, C_out, V_out  output  1 each  condition codes for the PSR.
REQ-012 S_bit_out  output  1  flag-write enable to the PSR.
REQ-013 busy_out  output  1  high in every non-IDLE state.
REQ-014 done_out  output  1  high for exactly one cycle; result and flags are valid.

Function
REQ-015 States: IDLE, MULT, ACC, DONE. Encoding is binary and defined in the package.
REQ-016 Transitions:
  - IDLE -> MULT when start_in=1, capturing all operand and control inputs.
  - MULT -> ACC after WIDTH iterations if the captured accumulate flag=1; otherwise MULT -> DONE.
  - ACC -> DONE after one cycle.
  - DONE -> IDLE unconditionally.
REQ-017 MULT: radix-2 shift-add, one multiplier bit per cycle, LSB first; iteration counter 0..WIDTH-1. No early termination.
REQ-018 Latency: with start accepted at edge k, done_out is high in the cycle after edge k+WIDTH+1 (MUL) or edge k+WIDTH+2 (MLA). For WIDTH=32 that is 33 or 34 cycles.
REQ-019 Arithmetic: all sums are modulo 2^WIDTH; upper product bits and the accumulate carry are discarded.
REQ-020 Flags when done_out=1:
  - N_out = result_out[WIDTH-1].
  - Z_out = 1 if and only if result_out == 0.
  - C_out = captured C_in.
  - V_out = captured V_in.
REQ-021 S_bit_out equals the captured S bit while done_out=1 and is 0 in all other cycles, so the PSR never latches intermediate values.
REQ-022 result_out and the flags hold their values from DONE until the next DONE; they are don't-care-stable while busy.
REQ-023 start_in while busy_out=1 is ignored, with no queuing. start_in in the DONE cycle is also ignored.
REQ-024 Operand inputs may change freely after capture without affecting the result.
REQ-025 The same register may feed Rm and Rs (equal operands); no restriction.

Reset
REQ-026 While reset=1: state is IDLE, counter is 0, and result_out, all flags, S_bit_out, busy_out and done_out are 0.
REQ-027 Reset during MULT or ACC aborts the operation. No done_out is produced, and the next operation starts cleanly after a new start_in.
REQ-028 Reset deassertion is taken at a clock edge; start_in is sampled from the first edge with reset=0.

Structure
REQ-029 Shared package contents:
  - state typedef and encoding;
  - WIDTH default;
  - counter width, $clog2(WIDTH).
REQ-030 Sub-module flag_gen (combinational) derives N and Z from a result and passes C/V through. The PSR-facing logic reuses it.
REQ-031 A single always_ff holds the state, counter and datapath registers; next-state logic is in a separate combinational block.

Verification
REQ-032 MUL 3*5, S=1, C_in=1, V_in=0:
  - result 0x0000000F, N=0, Z=0, C=1, V=0;
  - done in cycle 33 after start;
  - S_bit_out=1 for that one cycle only.
REQ-033 MUL 0xFFFFFFFF*1, S=0 -> result 0xFFFFFFFF, N=1, Z=0, S_bit_out=0 throughout.
REQ-034 MUL 0x00010000*0x00010000 -> result 0x00000000, Z=1, N=0 (wrap-around).
REQ-035 MLA 2*3+4 -> result 0x0000000A. Also MLA 0xFFFFFFFF*1+1 -> result 0, Z=1. Both finish with done in cycle 34.
REQ-036 Start pulse at cycle 10 of a busy operation -> ignored; exactly one done_out; result from the first operands.
REQ-037 Reset asserted at iteration 16 -> all outputs 0 immediately, no done_out; a subsequent 7*6 yields 0x0000002A.
